// File: rtl/bool_exp_pkg.sv
// Shared definitions for BOOL_EXP (OUT = ~A & B) checking and stimulus.
// Contents: FSM state enum, Gray-ordered vector table, reference function,
// and a counter-width helper.
package bool_exp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } bool_exp_state_e;

  localparam int unsigned NUM_VEC = 4;

  // {a,b} sweep order; index 0 is the LSB element: 00, 01, 11, 10.
  localparam logic [NUM_VEC-1:0][1:0] VEC_ORDER = {2'b10, 2'b11, 2'b01, 2'b00};

  // Single source of truth for the BOOL_EXP reference.
  function automatic logic expected_out(input logic a, input logic b);
    return ~a & b;
  endfunction

  // Bits needed to hold 0..max_val, never less than 1.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/bool_exp_settle_timer.sv
// Settle-time down-counter: loaded with SETTLE_CYCLES on each new vector,
// flags the last cycle of the hold window while enabled.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   i_load            reload the counter (new vector presented next cycle)
//   i_en              counting enabled (sweep in progress)
//   o_sample_now_c    combinational: this is the sampling cycle
module bool_exp_settle_timer
  import bool_exp_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_en,
  output logic o_sample_now_c
);

  localparam int unsigned CNT_W = cnt_width(SETTLE_CYCLES);

  logic [CNT_W-1:0] r_cnt;

  // Load has priority so a reload on the sampling cycle starts a fresh window.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CNT_W'(SETTLE_CYCLES);
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_sample_now_c = i_en && (r_cnt == '0);

endmodule

// File: rtl/bool_exp_stim_driver.sv
// Stimulus driver and self-checker for BOOL_EXP (OUT = ~A & B).
// Sweeps {a,b} in Gray order PASSES times, holds each vector SETTLE_CYCLES+1
// cycles, samples out_i on the last cycle and scores it against the reference.
// Ports:
//   clk, rst, start          clock, sync active-high reset, run request
//   a_o, b_o                 drive BOOL_EXP inputs
//   out_i                    BOOL_EXP output under test
//   busy, done, pass         run status (pass valid while done)
//   err_cnt                  saturating mismatch count
//   first_err_valid/_vec     first failing {a,b} of the run
//   cov_mask                 per-vector matched coverage, bit index {a,b}
//   cov_rise, cov_fall       output transition coverage over known samples
module bool_exp_stim_driver
  import bool_exp_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned PASSES        = 1,
  parameter int unsigned ERR_CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 a_o,
  output logic                 b_o,
  input  logic                 out_i,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 first_err_valid,
  output logic [1:0]           first_err_vec,
  output logic [3:0]           cov_mask,
  output logic                 cov_rise,
  output logic                 cov_fall
);

  localparam int unsigned PASS_W = cnt_width(PASSES - 1);

  bool_exp_state_e      r_state;
  logic [1:0]           r_vec_idx;
  logic [PASS_W-1:0]    r_pass_cnt;
  logic                 r_a;
  logic                 r_b;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_pass;
  logic [ERR_CNT_W-1:0] r_err_cnt;
  logic                 r_first_err_valid;
  logic [1:0]           r_first_err_vec;
  logic [3:0]           r_cov_mask;
  logic                 r_cov_rise;
  logic                 r_cov_fall;
  logic                 r_prev_valid;
  logic                 r_prev_val;

  logic                 w_sample;
  logic                 w_start_ok;
  logic                 w_unknown;
  logic                 w_mismatch;
  logic                 w_last_vec;
  logic                 w_last_pass;
  logic                 w_final;
  logic                 w_timer_load;
  logic [1:0]           w_next_idx;
  logic [1:0]           w_cur_vec;
  logic [ERR_CNT_W-1:0] w_err_next;

  assign w_start_ok  = start && (r_state != RUN);
  assign w_cur_vec   = {r_a, r_b};
  // X/Z on the output under test is always a failure; synthesis sees it as 0.
  assign w_unknown   = $isunknown(out_i);
  assign w_mismatch  = w_unknown || (out_i != expected_out(r_a, r_b));
  assign w_last_vec  = (r_vec_idx == 2'd3);
  assign w_last_pass = (r_pass_cnt == PASS_W'(PASSES - 1));
  assign w_final     = w_sample && w_last_vec && w_last_pass;
  assign w_next_idx  = 2'(r_vec_idx + 2'd1);
  assign w_err_next  = (w_mismatch && !(&r_err_cnt)) ? ERR_CNT_W'(r_err_cnt + 1'b1)
                                                     : r_err_cnt;
  assign w_timer_load = w_start_ok || (w_sample && !w_final);

  bool_exp_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle_timer (
    .clk           (clk),
    .rst           (rst),
    .i_load        (w_timer_load),
    .i_en          (r_state == RUN),
    .o_sample_now_c(w_sample)
  );

  // Run FSM, vector sequencing and scoreboard.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state           <= IDLE;
      r_vec_idx         <= '0;
      r_pass_cnt        <= '0;
      r_a               <= 1'b0;
      r_b               <= 1'b0;
      r_busy            <= 1'b0;
      r_done            <= 1'b0;
      r_pass            <= 1'b0;
      r_err_cnt         <= '0;
      r_first_err_valid <= 1'b0;
      r_first_err_vec   <= '0;
      r_cov_mask        <= '0;
      r_cov_rise        <= 1'b0;
      r_cov_fall        <= 1'b0;
      r_prev_valid      <= 1'b0;
      r_prev_val        <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_state           <= RUN;
            r_vec_idx         <= '0;
            r_pass_cnt        <= '0;
            {r_a, r_b}        <= VEC_ORDER[0];
            r_busy            <= 1'b1;
            r_done            <= 1'b0;
            r_pass            <= 1'b0;
            r_err_cnt         <= '0;
            r_first_err_valid <= 1'b0;
            r_first_err_vec   <= '0;
            r_cov_mask        <= '0;
            r_cov_rise        <= 1'b0;
            r_cov_fall        <= 1'b0;
            r_prev_valid      <= 1'b0;
            r_prev_val        <= 1'b0;
          end
        end
        RUN: begin
          if (w_sample) begin
            r_err_cnt <= w_err_next;
            if (w_mismatch) begin
              if (!r_first_err_valid) begin
                r_first_err_valid <= 1'b1;
                r_first_err_vec   <= w_cur_vec;
              end
            end else begin
              r_cov_mask[w_cur_vec] <= 1'b1;
            end
            // Edge history only spans known samples; X/Z breaks the chain.
            if (w_unknown) begin
              r_prev_valid <= 1'b0;
            end else begin
              if (r_prev_valid && !r_prev_val && out_i) r_cov_rise <= 1'b1;
              if (r_prev_valid && r_prev_val && !out_i) r_cov_fall <= 1'b1;
              r_prev_valid <= 1'b1;
              r_prev_val   <= out_i;
            end

            if (w_final) begin
              r_state    <= DONE;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
              r_pass     <= (w_err_next == '0);
              r_a        <= 1'b0;
              r_b        <= 1'b0;
              r_vec_idx  <= '0;
              r_pass_cnt <= '0;
            end else begin
              r_vec_idx  <= w_next_idx;
              {r_a, r_b} <= VEC_ORDER[w_next_idx];
              if (w_last_vec) r_pass_cnt <= PASS_W'(r_pass_cnt + 1'b1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign a_o             = r_a;
  assign b_o             = r_b;
  assign busy            = r_busy;
  assign done            = r_done;
  assign pass            = r_pass;
  assign err_cnt         = r_err_cnt;
  assign first_err_valid = r_first_err_valid;
  assign first_err_vec   = r_first_err_vec;
  assign cov_mask        = r_cov_mask;
  assign cov_rise        = r_cov_rise;
  assign cov_fall        = r_cov_fall;

endmodule

// File: tb/tb_bool_exp_stim_driver.sv
// Bench for bool_exp_stim_driver: emulates good and faulty BOOL_EXP blocks,
// predicts each run's results from its own behavioural model into a queue,
// and compares them when the run completes.
module tb_bool_exp_stim_driver;

  typedef struct packed {
    logic [7:0] err;
    logic       fev_valid;
    logic [1:0] fev;
    logic [3:0] mask;
    logic       rise;
    logic       fall;
    logic       pass;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic sel;
  int   mode_r;
  logic xv;

  logic       d1_a, d1_b, d1_out, d1_busy, d1_done, d1_pass, d1_fev_valid, d1_rise, d1_fall;
  logic [7:0] d1_err;
  logic [1:0] d1_fev;
  logic [3:0] d1_mask;
  logic       d2_a, d2_b, d2_out, d2_busy, d2_done, d2_pass, d2_fev_valid, d2_rise, d2_fall;
  logic [7:0] d2_err;
  logic [1:0] d2_fev;
  logic [3:0] d2_mask;

  logic       m_a, m_b, m_busy, m_done, m_pass, m_fev_valid, m_rise, m_fall;
  logic [7:0] m_err;
  logic [1:0] m_fev;
  logic [3:0] m_mask;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  // Emulated BOOL_EXP variants: 0 good, 1 stuck-at-1, 2 a&~b, 3 X while {a,b}=01.
  function automatic logic drv_out(input int mode, input logic a, input logic b, input logic x);
    case (mode)
      0:       return ~a & b;
      1:       return 1'b1;
      2:       return a & ~b;
      default: return (!a && b) ? x : (~a & b);
    endcase
  endfunction

  // Behavioural prediction of a complete run.
  function automatic exp_t predict(input int mode, input int passes, input logic x);
    exp_t       e;
    int         cnt;
    logic       pv, pval, o, ex, bad;
    logic [1:0] v;
    logic [1:0] order [4];
    order = '{2'b00, 2'b01, 2'b11, 2'b10};
    e = '0; cnt = 0; pv = 1'b0; pval = 1'b0;
    for (int p = 0; p < passes; p++) begin
      for (int k = 0; k < 4; k++) begin
        v   = order[k];
        ex  = (v == 2'b01);
        o   = drv_out(mode, v[1], v[0], x);
        bad = $isunknown(o) || (o != ex);
        if (bad) begin
          cnt++;
          if (!e.fev_valid) begin
            e.fev_valid = 1'b1;
            e.fev       = v;
          end
        end else begin
          e.mask[v] = 1'b1;
        end
        if ($isunknown(o)) begin
          pv = 1'b0;
        end else begin
          if (pv && !pval && o) e.rise = 1'b1;
          if (pv && pval && !o) e.fall = 1'b1;
          pv = 1'b1; pval = o;
        end
      end
    end
    e.err  = (cnt > 255) ? 8'hFF : 8'(cnt);
    e.pass = (cnt == 0);
    return e;
  endfunction

  always_comb d1_out = drv_out(mode_r, d1_a, d1_b, xv);
  always_comb d2_out = drv_out(mode_r, d2_a, d2_b, xv);

  bool_exp_stim_driver #(.SETTLE_CYCLES(2), .PASSES(1), .ERR_CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start && !sel), .a_o(d1_a), .b_o(d1_b), .out_i(d1_out),
    .busy(d1_busy), .done(d1_done), .pass(d1_pass), .err_cnt(d1_err),
    .first_err_valid(d1_fev_valid), .first_err_vec(d1_fev), .cov_mask(d1_mask),
    .cov_rise(d1_rise), .cov_fall(d1_fall)
  );

  bool_exp_stim_driver #(.SETTLE_CYCLES(0), .PASSES(100), .ERR_CNT_W(8)) dut_sat (
    .clk(clk), .rst(rst), .start(start && sel), .a_o(d2_a), .b_o(d2_b), .out_i(d2_out),
    .busy(d2_busy), .done(d2_done), .pass(d2_pass), .err_cnt(d2_err),
    .first_err_valid(d2_fev_valid), .first_err_vec(d2_fev), .cov_mask(d2_mask),
    .cov_rise(d2_rise), .cov_fall(d2_fall)
  );

  always_comb begin
    if (sel) begin
      {m_a, m_b, m_busy, m_done, m_pass, m_fev_valid, m_rise, m_fall} =
        {d2_a, d2_b, d2_busy, d2_done, d2_pass, d2_fev_valid, d2_rise, d2_fall};
      m_err = d2_err; m_fev = d2_fev; m_mask = d2_mask;
    end else begin
      {m_a, m_b, m_busy, m_done, m_pass, m_fev_valid, m_rise, m_fall} =
        {d1_a, d1_b, d1_busy, d1_done, d1_pass, d1_fev_valid, d1_rise, d1_fall};
      m_err = d1_err; m_fev = d1_fev; m_mask = d1_mask;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ab"},   32'({m_a, m_b}), 0);
    check({tag, "_busy"}, 32'(m_busy), 0);
    check({tag, "_done"}, 32'(m_done), 0);
    check({tag, "_pass"}, 32'(m_pass), 0);
    check({tag, "_err"},  32'(m_err), 0);
    check({tag, "_fev"},  32'({m_fev_valid, m_fev}), 0);
    check({tag, "_cov"},  32'({m_mask, m_rise, m_fall}), 0);
  endtask

  // One complete run; optional start pulses while busy must be ignored.
  task automatic run(input int mode, input int passes, input int settle,
                     input logic use2, input logic ign);
    exp_t e;
    int   bc;
    sel    = use2;
    mode_r = mode;
    @(negedge clk);
    start = 1'b1;
    sb.push_back(predict(mode, passes, xv));
    @(negedge clk);
    start = 1'b0;
    check("c1_busy", 32'(m_busy), 1);
    check("c1_vec0", 32'({m_a, m_b}), 0);
    check("c1_clr",  32'({m_done, m_pass, m_err, m_fev_valid, m_mask, m_rise, m_fall}), 0);
    bc = 0;
    while (m_busy && bc < 5000) begin
      bc++;
      start = ign && (bc == 3 || bc == 7);
      @(negedge clk);
    end
    start = 1'b0;
    check("busy_len", 32'(bc), 32'(passes * 4 * (settle + 1)));
    check("done",     32'(m_done), 1);
    check("end_ab",   32'({m_a, m_b}), 0);
    if (sb.size() == 0) begin
      check("sb_empty", 32'(sb.size()), 1);
    end else begin
      e = sb.pop_front();
      check("err_cnt",   32'(m_err), 32'(e.err));
      check("pass",      32'(m_pass), 32'(e.pass));
      check("fev_valid", 32'(m_fev_valid), 32'(e.fev_valid));
      if (e.fev_valid) check("fev", 32'(m_fev), 32'(e.fev));
      check("cov_mask",  32'(m_mask), 32'(e.mask));
      check("cov_rise",  32'(m_rise), 32'(e.rise));
      check("cov_fall",  32'(m_fall), 32'(e.fall));
    end
  endtask

  initial begin
    xv     = 1'bx;
    rst    = 1'b1;
    start  = 1'b0;
    sel    = 1'b0;
    mode_r = 0;
    repeat (3) @(negedge clk);
    check_all_zero("rst1");
    sel = 1'b1;
    #1 check_all_zero("rst2");
    sel = 1'b0;

    // start coinciding with reset: reset wins
    start = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check_all_zero("rst_start");

    run(0, 1, 2, 1'b0, 1'b0);
    run(1, 1, 2, 1'b0, 1'b0);
    run(2, 1, 2, 1'b0, 1'b0);
    run(3, 1, 2, 1'b0, 1'b0);

    // Reset in cycle 5 of a run
    mode_r = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_busy", 32'(m_busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("mid_rst");

    run(0, 1, 2, 1'b0, 1'b1);
    run(1, 100, 0, 1'b1, 1'b0);

    check("sb_drained", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
